write_index_pipe: RTL and testbench
===================================

Name: write_index_pipe

Overview:
- Parametrised elastic successor to the fixed write→index pipeline register.
- Carries strip_ID, occupied_width and strike from the write stage to the index stage through STAGES register stages.
- Adds a valid/ready handshake, per-stage backpressure with bubble collapsing, a synchronous flush and an occupancy output.
- Sits between the write and index stages of the placement pipeline.

Parameters:
- ID_W, 4, strip_ID width.
- OCC_W, 8, occupied_width width.
- STRIKE_W, 4, strike width.
- STAGES, 2, number of register stages; legal range 1..8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discard all in-flight entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  pipe can accept an entry this cycle.
- strip_ID_in  input  ID_W  upstream strip ID.
- occupied_width_in  input  OCC_W  upstream occupied width.
- strike_in  input  STRIKE_W  upstream strike count.
- out_valid  output  1  entry available to index stage.
- out_ready  input  1  index stage accepts the entry.
- strip_ID_out  output  ID_W  downstream strip ID.
- occupied_width_out  output  OCC_W  downstream occupied width.
- strike_out  output  STRIKE_W  downstream strike count.
- occupancy  output  $clog2(STAGES+1)  number of valid stages.
- stall_cnt  output  16  backpressure stall counter (see Optional Feature).

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - rst is synchronous and active-high; it is sampled on the rising edge of clk.
  - Reset clears every stage valid bit, every data register, occupancy and stall_cnt to 0.
  - Reset has priority over flush and over any transfer. A reset asserted mid-stream drops all entries.
- Stages and outputs:
  - Stages are numbered 0 (input side) to STAGES-1 (output side). Each stage has a valid bit v[k] and a data word {ID, OCC, STRIKE}.
  - out_valid = v[STAGES-1]. Data outputs come straight from the stage STAGES-1 registers, with no combinational path from the inputs.
- Ready chain (combinational):
  - rdy[STAGES] = out_ready.
  - rdy[k] = !v[k] || rdy[k+1].
  - in_ready = rdy[0] && !flush.
- Advance rule (no reset, no flush), applied on each clk edge:
  - Stage k with rdy[k]=1 loads from stage k-1; stage 0 loads from the inputs. Its valid bit v[k] takes the source's valid.
  - The data word loads only when the source is valid. Otherwise the data holds, which avoids needless toggling.
  - A stage with rdy[k]=0 holds both its valid bit and its data.
- Handshakes:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - Both may occur in the same cycle. With a full pipe and out_ready=1, throughput is 1 entry/cycle.
  - Bubbles collapse: an empty stage accepts even when the downstream stage is stalled.
- Latency: STAGES cycles from input transfer to out_valid when there is no backpressure.
- Upstream contract: while in_valid && !in_ready, upstream holds in_valid and its data stable. The block does not check this.
- Flush:
  - On a clk edge with flush=1, all v[k] are cleared to 0. Data registers keep their old values.
  - Input presented in the flush cycle is dropped (in_ready=0).
  - An output transfer in the flush cycle still counts as delivered, because the index stage sampled it.
  - The cycle after a flush: occupancy=0, out_valid=0.
- Occupancy:
  - occupancy = popcount of v[k], as a registered value that is consistent with the v bits after each edge.
  - Full: occupancy==STAGES and in_ready equals out_ready.
  - Empty: occupancy==0 and out_valid=0.
- stall_cnt counts cycles with out_valid && !out_ready.
  - It saturates at 16'hFFFF and does not wrap.
  - It clears on rst only; flush does not clear it.

Optional Feature:
- Macro: WRITE_INDEX_PIPE_STALL_CNT_EN.
- Defined: stall_cnt is implemented as described in Behaviour.
- Undefined: the counter logic is removed and stall_cnt is tied to 16'h0000. The port list is unchanged.

Test Plan:
- Streaming, STAGES=2, out_ready=1:
  - Stimulus: push ID=1..5 on consecutive cycles, OCC=8'h10+ID, STRIKE=ID.
  - Response: out_valid rises 2 cycles after the first transfer; outputs appear in order 1..5 on consecutive cycles; in_ready stays 1.
- Backpressure fill:
  - Stimulus: out_ready=0; push 3 entries (ID=7, 8, 9).
  - Response: occupancy reaches 2; in_ready=0 after the 2nd transfer; ID=9 is held upstream; stall_cnt increments every cycle out_valid=1.
  - Release: set out_ready=1; outputs are 7, 8, 9 in order with no loss or duplication.
- Bubble collapse:
  - Stimulus: STAGES=3; one entry ID=3 at the output with out_ready=0; push ID=4.
  - Response: ID=4 advances to stage 1 in 2 cycles; occupancy=2.
- Flush during traffic:
  - Stimulus: pipe holds 2 entries; assert flush for 1 cycle with in_valid=1, out_ready=1.
  - Response: in_ready=0 in that cycle; the output entry is delivered; next cycle occupancy=0, out_valid=0; the input in the flush cycle never emerges.
- Reset mid-operation:
  - Stimulus: full pipe with stall_cnt=12; assert rst for 1 cycle.
  - Response: next cycle all outputs are 0; occupancy=0; stall_cnt=0; in_ready=1.
  - Also repeat the backpressure test with WRITE_INDEX_PIPE_STALL_CNT_EN undefined → stall_cnt stays 0.

Source files
------------

// File: rtl/write_index_pipe.sv
// write_index_pipe: elastic register pipeline carrying {strip_ID, occupied_width,
// strike} from the write stage to the index stage of the placement pipeline.
// Valid/ready handshake, per-stage backpressure with bubble collapsing,
// synchronous flush and a registered occupancy count.
// Optional feature macro: WRITE_INDEX_PIPE_STALL_CNT_EN enables the saturating
// backpressure stall counter; when undefined stall_cnt is tied to zero.
module write_index_pipe #(
  parameter int ID_W     = 4,
  parameter int OCC_W    = 8,
  parameter int STRIKE_W = 4,
  parameter int STAGES   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ID_W-1:0]                  strip_ID_in,
  input  logic [OCC_W-1:0]                 occupied_width_in,
  input  logic [STRIKE_W-1:0]              strike_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ID_W-1:0]                  strip_ID_out,
  output logic [OCC_W-1:0]                 occupied_width_out,
  output logic [STRIKE_W-1:0]              strike_out,
  output logic [$clog2(STAGES+1)-1:0]      occupancy,
  output logic [15:0]                      stall_cnt
);

  localparam int DW     = ID_W + OCC_W + STRIKE_W;
  localparam int OCC_CW = $clog2(STAGES+1);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_next;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_v;
  logic [DW-1:0]     data_q [STAGES];
  logic [DW-1:0]     src_d  [STAGES];
  logic [OCC_CW-1:0] occ_next;

  // Ready chain from the output side back: a stage can load if it is empty or
  // the stage after it can move on, so empty stages absorb bubbles.
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      r      = !v[k] || r;
      rdy[k] = r;
    end
  end

  assign in_ready = rdy[0] && !flush;

  // Source of each stage: stage 0 takes the upstream inputs, the rest take
  // the preceding stage.
  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    src_d[0] = {strip_ID_in, occupied_width_in, strike_in};
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v[k-1];
      src_d[k] = data_q[k-1];
    end
  end

  // Next valid bits and their popcount, so occupancy stays in step with v.
  always_comb begin
    v_next   = '0;
    occ_next = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (flush) begin
        v_next[k] = 1'b0;
      end else if (rdy[k]) begin
        v_next[k] = src_v[k];
      end else begin
        v_next[k] = v[k];
      end
      occ_next = occ_next + OCC_CW'(v_next[k]);
    end
  end

  // Stage registers: data only loads from a valid source to avoid toggling,
  // and flush clears valids while leaving the data words untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      v         <= '0;
      occupancy <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v         <= v_next;
      occupancy <= occ_next;
      for (int k = 0; k < STAGES; k++) begin
        if (!flush && rdy[k] && src_v[k]) begin
          data_q[k] <= src_d[k];
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign {strip_ID_out, occupied_width_out, strike_out} = data_q[STAGES-1];

`ifdef WRITE_INDEX_PIPE_STALL_CNT_EN
  // Saturating count of cycles where the index stage refuses a ready entry;
  // only reset clears it so it survives flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_write_index_pipe.sv
// tb_write_index_pipe: scoreboard bench for write_index_pipe with STAGES=2.
// Expected entries are queued on each accepted input and compared on each
// delivered output; directed sections cover streaming, backpressure, bubble
// collapse, flush and mid-stream reset.
module tb_write_index_pipe;

  localparam int ID_W     = 4;
  localparam int OCC_W    = 8;
  localparam int STRIKE_W = 4;
  localparam int STAGES   = 2;
  localparam int OCC_CW   = $clog2(STAGES+1);

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [ID_W-1:0]      strip_ID_in;
  logic [OCC_W-1:0]     occupied_width_in;
  logic [STRIKE_W-1:0]  strike_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [ID_W-1:0]      strip_ID_out;
  logic [OCC_W-1:0]     occupied_width_out;
  logic [STRIKE_W-1:0]  strike_out;
  logic [OCC_CW-1:0]    occupancy;
  logic [15:0]          stall_cnt;

  int          check_count;
  int          error_count;
  logic [15:0] sb [$];
  logic [15:0] stall_exp;
  bit          accepted;

  write_index_pipe #(
    .ID_W(ID_W), .OCC_W(OCC_W), .STRIKE_W(STRIKE_W), .STAGES(STAGES)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .strip_ID_in(strip_ID_in), .occupied_width_in(occupied_width_in),
    .strike_in(strike_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .strip_ID_out(strip_ID_out), .occupied_width_out(occupied_width_out),
    .strike_out(strike_out),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle's worth of inputs; entry fields derive from the ID.
  task automatic applyStimulus(input bit r, input bit f, input bit iv,
                               input logic [3:0] id, input bit ordy);
    rst               = r;
    flush             = f;
    in_valid          = iv;
    strip_ID_in       = id;
    occupied_width_in = 8'h10 + 8'(id);
    strike_in         = id;
    out_ready         = ordy;
  endtask

  // One clock: checks handshake-side expectations, updates the scoreboard at
  // the edge and checks the stall counter afterwards.
  task automatic stepCycle(output bit in_tx);
    bit out_tx;
    bit exp_in_ready;
    #1;
    exp_in_ready = !flush && ((sb.size() < STAGES) || out_ready);
    checkOutput("in_ready", in_ready, exp_in_ready);
    checkOutput("occupancy", occupancy, sb.size());
    if (sb.size() == 0) checkOutput("empty_out_valid", out_valid, 1'b0);
    in_tx  = in_valid && in_ready;
    out_tx = out_valid && out_ready;
    if (out_tx) begin
      if (sb.size() == 0) checkOutput("unexpected_output", 1'b1, 1'b0);
      else checkOutput("out_data", {strip_ID_out, occupied_width_out, strike_out}, sb.pop_front());
    end
`ifdef WRITE_INDEX_PIPE_STALL_CNT_EN
    if (out_valid && !out_ready && stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'd1;
`endif
    if (rst) begin
      sb.delete();
      stall_exp = 16'h0000;
    end else begin
      if (in_tx) sb.push_back({strip_ID_in, occupied_width_in, strike_in});
      if (flush) sb.delete();
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall_cnt", stall_cnt, stall_exp);
  endtask

  // Empties the pipe with out_ready high, bounded by a cycle budget.
  task automatic drain(input int max_cycles);
    bit tx;
    applyStimulus(0, 0, 0, 4'd0, 1);
    for (int i = 0; i < max_cycles && sb.size() > 0; i++) stepCycle(tx);
    checkOutput("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    stall_exp   = 16'h0000;
    applyStimulus(1, 0, 0, 4'd0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    applyStimulus(0, 0, 0, 4'd0, 0);
    #1;
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_occupancy", occupancy, 0);
    checkOutput("reset_data", {strip_ID_out, occupied_width_out, strike_out}, 16'h0000);
    checkOutput("reset_stall_cnt", stall_cnt, 16'h0000);
    checkOutput("reset_in_ready", in_ready, 1'b1);

    // Streaming: IDs 1..5 back-to-back, output ready throughout
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 4'(i + 1), 1);
      stepCycle(accepted);
      checkOutput("stream_accept", accepted, 1'b1);
      checkOutput("stream_out_valid", out_valid, (i >= 1));
    end
    drain(10);

    // Backpressure fill: 7 and 8 enter, 9 is held upstream
    applyStimulus(0, 0, 1, 4'd7, 0);
    stepCycle(accepted);
    applyStimulus(0, 0, 1, 4'd8, 0);
    stepCycle(accepted);
    checkOutput("bp_occupancy", occupancy, 2);
    checkOutput("bp_out_valid", out_valid, 1'b1);
    applyStimulus(0, 0, 1, 4'd9, 0);
    for (int i = 0; i < 3; i++) begin
      stepCycle(accepted);
      checkOutput("bp_held", accepted, 1'b0);
    end
    applyStimulus(0, 0, 1, 4'd9, 1);
    accepted = 1'b0;
    for (int i = 0; i < 5 && !accepted; i++) stepCycle(accepted);
    checkOutput("bp_release_accept", accepted, 1'b1);
    drain(10);

    // Bubble collapse: 3 stalled at the output, 4 still moves in behind it
    applyStimulus(0, 0, 1, 4'd3, 0);
    stepCycle(accepted);
    applyStimulus(0, 0, 0, 4'd0, 0);
    stepCycle(accepted);
    checkOutput("bubble_head_valid", out_valid, 1'b1);
    checkOutput("bubble_head_id", strip_ID_out, 4'd3);
    applyStimulus(0, 0, 1, 4'd4, 0);
    stepCycle(accepted);
    checkOutput("bubble_accept", accepted, 1'b1);
    checkOutput("bubble_occupancy", occupancy, 2);
    checkOutput("bubble_head_hold", strip_ID_out, 4'd3);
    drain(10);

    // Flush during traffic: head is delivered, the rest and the new input vanish
    applyStimulus(0, 0, 1, 4'd10, 0);
    stepCycle(accepted);
    applyStimulus(0, 0, 1, 4'd11, 0);
    stepCycle(accepted);
    checkOutput("flush_pre_occupancy", occupancy, 2);
    applyStimulus(0, 1, 1, 4'd12, 1);
    stepCycle(accepted);
    checkOutput("flush_drop_input", accepted, 1'b0);
    checkOutput("flush_out_valid", out_valid, 1'b0);
    checkOutput("flush_occupancy", occupancy, 0);
    applyStimulus(0, 0, 0, 4'd0, 1);
    for (int i = 0; i < 4; i++) stepCycle(accepted);

    // Reset mid-operation with a full, stalled pipe
    applyStimulus(0, 0, 1, 4'd13, 0);
    stepCycle(accepted);
    applyStimulus(0, 0, 1, 4'd14, 0);
    stepCycle(accepted);
    applyStimulus(0, 0, 0, 4'd0, 0);
    for (int i = 0; i < 10; i++) stepCycle(accepted);
    checkOutput("pre_reset_occupancy", occupancy, 2);
    applyStimulus(1, 0, 0, 4'd0, 0);
    stepCycle(accepted);
    applyStimulus(0, 0, 0, 4'd0, 0);
    #1;
    checkOutput("mid_reset_out_valid", out_valid, 1'b0);
    checkOutput("mid_reset_data", {strip_ID_out, occupied_width_out, strike_out}, 16'h0000);
    checkOutput("mid_reset_occupancy", occupancy, 0);
    checkOutput("mid_reset_stall_cnt", stall_cnt, 16'h0000);
    checkOutput("mid_reset_in_ready", in_ready, 1'b1);

    // Random traffic after reset, checked by the scoreboard
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                    4'($urandom_range(0, 15)), $urandom_range(0, 1));
      stepCycle(accepted);
    end
    drain(10);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
